// File: rtl/canvas_pkg.sv
// canvas_pkg: shared constants, state encoding and pixel-address packing for the canvas buffer
package canvas_pkg;
    localparam int SIDE = 32;
    localparam int COORD_W = $clog2(SIDE);
    localparam int ADDR_W = 2 * COORD_W;
    localparam int CHAR_W = 8;
    localparam int TIMEOUT = 2047;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CHAR_W-1:0] FAIL_CHAR = 8'h3F;

    typedef enum logic [1:0] {CLEAR, DRAW, SUBMIT, WAIT} state_t;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] y, input logic [COORD_W-1:0] x);
        return {y, x};
    endfunction
endpackage

// File: rtl/canvas_bitmap_ram.sv
// canvas_bitmap_ram: 1024x1 bitmap, synchronous write, asynchronous read
module canvas_bitmap_ram
    import canvas_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic              i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic              o_rdata
);
    logic r_mem [0:SIDE*SIDE-1];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/canvas_buffer.sv
// canvas_buffer: drawing canvas memory, submit handshake and result capture for the recognizer
module canvas_buffer
    import canvas_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        pen_x,
    input  logic [4:0]        pen_y,
    input  logic              pen_down,
    input  logic              pen_erase,
    input  logic              clear_req,
    input  logic              submit_req,
    output logic              end_write,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic              read_enable,
    output logic              read_in_data,
    input  logic              ready_to_write,
    input  logic [CHAR_W-1:0] write_data,
    output logic [CHAR_W-1:0] result_char,
    output logic              result_valid,
    output logic              busy
);
    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_end_write;
    logic [CHAR_W-1:0]   r_char;
    logic                r_valid;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic                w_wdata;
    logic                w_rdata;

    // write port belongs to the clear sweep in CLEAR, to the pen in DRAW
    always_comb begin
        w_we = (r_state == CLEAR) || (r_state == DRAW && pen_down && !clear_req);
        w_waddr = (r_state == CLEAR) ? r_clr : pix_addr(pen_y, pen_x);
        w_wdata = (r_state != CLEAR) && !pen_erase;
    end

    canvas_bitmap_ram u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (read_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
            r_clr <= '0;
            r_tmo <= '0;
            r_end_write <= 1'b0;
            r_char <= '0;
            r_valid <= 1'b0;
        end else begin
            r_end_write <= 1'b0;
            case (r_state)
                CLEAR: begin
                    r_clr <= r_clr + 1'b1;
                    if (r_clr == ADDR_W'(SIDE * SIDE - 1)) r_state <= DRAW;
                end
                DRAW: begin
                    if (clear_req) begin
                        r_state <= CLEAR;
                        r_clr <= '0;
                        r_valid <= 1'b0;
                    end else if (submit_req) begin
                        r_state <= SUBMIT;
                        r_valid <= 1'b0;
                        r_end_write <= 1'b1;
                    end
                end
                SUBMIT: begin
                    r_tmo <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (ready_to_write) begin
                        r_char <= write_data;
                        r_valid <= 1'b1;
                        r_state <= DRAW;
                    end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                        r_tmo <= r_tmo + 1'b1;
                        r_char <= FAIL_CHAR;
                        r_valid <= 1'b1;
                        r_state <= DRAW;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    assign end_write = r_end_write;
    assign read_in_data = read_enable && w_rdata;
    assign result_char = r_char;
    assign result_valid = r_valid;
    assign busy = (r_state != DRAW);
endmodule

// File: tb/tb_canvas_buffer.sv
// tb_canvas_buffer: directed stimulus checked against a cycle-level behavioural model of the canvas
module tb_canvas_buffer;
    logic clk = 0, rst = 0;
    logic [4:0] pen_x = 0, pen_y = 0;
    logic pen_down = 0, pen_erase = 0, clear_req = 0, submit_req = 0;
    logic [9:0] read_addr = 0;
    logic read_enable = 0, ready_to_write = 0;
    logic [7:0] write_data = 0;
    logic end_write, read_in_data, result_valid, busy;
    logic [7:0] result_char;

    canvas_buffer dut (
        .clk(clk), .rst(rst), .pen_x(pen_x), .pen_y(pen_y), .pen_down(pen_down),
        .pen_erase(pen_erase), .clear_req(clear_req), .submit_req(submit_req),
        .end_write(end_write), .read_addr(read_addr), .read_enable(read_enable),
        .read_in_data(read_in_data), .ready_to_write(ready_to_write), .write_data(write_data),
        .result_char(result_char), .result_valid(result_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, ew_cnt = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: phase plus cycles left in it, and a plain bit array for the picture
    localparam int M_CLEAR = 0, M_DRAW = 1, M_SUB = 2, M_WAIT = 3;
    int m_mode, m_left;
    logic [7:0] m_char;
    logic m_valid, m_ew;
    bit m_mem [1024];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_CLEAR; m_left = 1024; m_char = 0; m_valid = 0; m_ew = 0;
        end else begin
            m_ew = 0;
            if (m_mode == M_CLEAR) begin
                m_mem[1024 - m_left] = 0;
                m_left--;
                if (m_left == 0) m_mode = M_DRAW;
            end else if (m_mode == M_DRAW) begin
                if (clear_req) begin
                    m_mode = M_CLEAR; m_left = 1024; m_valid = 0;
                end else begin
                    if (pen_down) m_mem[pen_y * 32 + pen_x] = !pen_erase;
                    if (submit_req) begin m_mode = M_SUB; m_valid = 0; m_ew = 1; end
                end
            end else if (m_mode == M_SUB) begin
                m_mode = M_WAIT; m_left = 2047;
            end else if (ready_to_write) begin
                m_char = write_data; m_valid = 1; m_mode = M_DRAW;
            end else begin
                m_left--;
                if (m_left == 0) begin m_char = 8'h3F; m_valid = 1; m_mode = M_DRAW; end
            end
        end
    end

    always @(negedge clk) begin
        if (end_write) ew_cnt++;
        if (chk_en) begin
            chk("busy", busy, m_mode != M_DRAW);
            chk("end_write", end_write, m_ew);
            chk("result_char", result_char, m_char);
            chk("result_valid", result_valid, m_valid);
            if (read_enable && m_mode != M_CLEAR) chk("read_in_data", read_in_data, m_mem[read_addr]);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic paint(input int x, input int y, input bit erase);
        pen_x = 5'(x); pen_y = 5'(y); pen_erase = erase; pen_down = 1;
        tick();
        pen_down = 0; pen_erase = 0;
    endtask

    task automatic rd(input int a, output logic d);
        read_addr = 10'(a); read_enable = 1; #1;
        d = read_in_data;
        read_enable = 0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 6000) begin n++; @(negedge clk); end
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ones, e0;
        logic d;
        #1 rst = 1;
        #1 chk_en = 1;
        chk("reset_busy", busy, 1);
        chk("reset_char", result_char, 0);
        chk("reset_valid", result_valid, 0);
        chk("reset_end_write", end_write, 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        busy_len(n);
        chk("clear_busy_cycles", n, 1024);
        tick();
        ones = 0;
        for (int i = 0; i < 1024; i++) begin rd(i, d); ones += int'(d); end
        chk("cleared_canvas_ones", ones, 0);

        paint(3, 5, 0);
        paint(4, 5, 0);
        paint(4, 5, 1);
        rd(163, d); chk("pixel_163", d, 1);
        rd(164, d); chk("pixel_164_erased", d, 0);
        read_addr = 163; #1;
        chk("read_disabled_zero", read_in_data, 0);

        paint(0, 0, 0);
        paint(31, 31, 0);
        pen_x = 10; pen_y = 2; pen_down = 1; submit_req = 1;
        tick();
        pen_down = 0; submit_req = 0;
        chk("end_write_high", end_write, 1);
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            read_addr = 10'(i); read_enable = 1;
            @(negedge clk);
            ones += int'(read_in_data);
            tick();
        end
        read_enable = 0;
        chk("sweep_ones", ones, 4);
        chk("end_write_pulses", ew_cnt, 1);

        pen_x = 0; pen_y = 0; pen_down = 1; pen_erase = 1; clear_req = 1; submit_req = 1;
        tick();
        pen_down = 0; pen_erase = 0; clear_req = 0; submit_req = 0;
        chk("wait_ignores_clear", busy, 1);
        rd(0, d); chk("wait_ignores_pen", d, 1);
        ready_to_write = 1; write_data = 8'h41;
        tick();
        ready_to_write = 0; write_data = 0;
        chk("result_char_41", result_char, 8'h41);
        chk("result_valid_41", result_valid, 1);
        chk("busy_after_result", busy, 0);

        submit_req = 1;
        tick();
        submit_req = 0;
        busy_len(n);
        chk("timeout_busy_cycles", n, 2048);
        chk("timeout_char", result_char, 8'h3F);
        chk("timeout_valid", result_valid, 1);

        tick();
        e0 = ew_cnt;
        clear_req = 1; submit_req = 1; pen_x = 5; pen_y = 5; pen_down = 1;
        tick();
        clear_req = 0; submit_req = 0; pen_down = 0;
        chk("clear_wins_busy", busy, 1);
        chk("clear_wins_valid", result_valid, 0);
        busy_len(n);
        chk("reclear_busy_cycles", n, 1024);
        chk("clear_wins_no_end_write", ew_cnt, e0);
        rd(165, d); chk("clear_wins_pen_dropped", d, 0);

        tick();
        paint(0, 0, 0);
        paint(1, 0, 0);
        submit_req = 1;
        tick();
        submit_req = 0;
        repeat (5) tick();
        #3 rst = 1;
        #1;
        chk("async_reset_char", result_char, 0);
        chk("async_reset_busy", busy, 1);
        @(posedge clk); #1 rst = 0;
        tick();
        rd(0, d); chk("restart_addr0_cleared", d, 0);
        rd(1, d); chk("restart_addr1_pending", d, 1);
        busy_len(n);
        chk("restart_busy_cycles", n, 1023);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/canvas_buffer.md
Name: canvas_buffer

Overview:
- Owns the 32x32 1-bit drawing canvas that the user paints into.
- On submit, pulses end_write and serves the recognizer's pixel reads from this memory.
- Captures the recognizer's result character (ready_to_write / write_data).
- Sits between the pen/input front-end and the character recognizer; it is the memory-side responder for the recognizer's read interface.

Parameters:
- SIDE, 32, canvas width and height in pixels; power of two.
- ADDR_W, 10, pixel address width, equal to 2*log2(SIDE).
- CHAR_W, 8, result character width.
- TIMEOUT, 2047, cycles to wait in WAIT before giving up; must exceed SIDE*SIDE+2.
- FAIL_CHAR, 8'h3F, character reported on timeout ('?').

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- pen_x  in  5  pen column.
- pen_y  in  5  pen row.
- pen_down  in  1  paint the pen pixel this cycle.
- pen_erase  in  1  with pen_down: write 0 instead of 1.
- clear_req  in  1  one-cycle request to blank the canvas.
- submit_req  in  1  one-cycle request to recognize the canvas.
- end_write  out  1  one-cycle pulse that starts the recognizer.
- read_addr  in  ADDR_W  recognizer pixel address: row = [9:5], column = [4:0].
- read_enable  in  1  recognizer read strobe.
- read_in_data  out  1  pixel at read_addr.
- ready_to_write  in  1  recognizer result strobe.
- write_data  in  CHAR_W  recognizer result character.
- result_char  out  CHAR_W  last captured result.
- result_valid  out  1  result_char holds a result for the current drawing.
- busy  out  1  high in every state except DRAW.

Behaviour:
- Reset (async): state = CLEAR, clear counter = 0, end_write = 0, result_char = 0, result_valid = 0, busy = 1, timeout counter = 0. Memory contents are not reset; the CLEAR sweep blanks them.
- Pixel address = {pen_y, pen_x}, i.e. row-major, matching the recognizer's read_addr split.
- Read port is combinational: read_in_data = mem[read_addr] when read_enable = 1, else 0.
  - Required because the recognizer samples data in the same cycle it presents the address.
  - The port is served in every state.
- CLEAR:
  - Writes 0 to address = clear counter each cycle.
  - After address 1023 is written (1024 cycles total), goes to DRAW.
  - Pen, submit and ready_to_write are ignored.
  - result_valid is cleared on entry.
- DRAW (busy = 0):
  - pen_down = 1 writes mem[{pen_y, pen_x}] <= ~pen_erase at the clock edge.
  - clear_req = 1 goes to CLEAR. It wins over submit_req, and the pen write in that cycle is dropped.
  - Otherwise submit_req = 1 goes to SUBMIT. A pen write in the same cycle is performed; result_valid <= 0.
  - ready_to_write in DRAW is ignored.
- SUBMIT:
  - One cycle; end_write = 1 (registered, so high exactly this cycle).
  - Timeout counter <= 0; next state WAIT.
- WAIT:
  - Pen, clear_req and submit_req are ignored and not queued.
  - ready_to_write = 1 sets result_char <= write_data and result_valid <= 1, then goes to DRAW.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT: result_char <= FAIL_CHAR, result_valid <= 1, go to DRAW.
  - If ready_to_write arrives in the same cycle the timeout is hit, ready_to_write wins.
- Expected recognizer timing:
  - Reads addresses 0..1023 on consecutive cycles, starting in the cycle end_write is high.
  - ready_to_write arrives about 1025 cycles after end_write.
  - TIMEOUT = 2047 leaves margin.
- The memory is never written in SUBMIT or WAIT, so the image is stable for the whole read sweep.
- Reset mid-operation (any state) restarts the CLEAR sweep from address 0 and drops any pending result.

Decomposition:
- Shared package canvas_pkg:
  - Constants SIDE, ADDR_W, CHAR_W, FAIL_CHAR.
  - State enum {CLEAR, DRAW, SUBMIT, WAIT}.
  - Pixel-address pack function {y, x}.
- One sub-module canvas_bitmap_ram: 1024x1, one synchronous write port, one asynchronous read port.
  - The top level muxes the write port between the clear sweep and the pen.

Test Plan:
- Release reset, count cycles -> busy = 1 for exactly 1024 cycles, then 0; every read_addr 0..1023 with read_enable = 1 returns 0.
- pen_down at (x=3, y=5), then pen_down + pen_erase at (x=4, y=5) -> read_addr 10'd163 returns 1, 10'd164 returns 0.
- Paint 4 pixels, pulse submit_req -> end_write high exactly 1 cycle after 1 cycle; a recognizer model sweeping 0..1023 sees exactly those 4 ones; ready_to_write with write_data = 8'h41 -> result_char = 8'h41, result_valid = 1, busy = 0.
- In WAIT, drive pen_down at (0,0) and clear_req -> no memory change, state stays WAIT; result unaffected.
- Submit with no recognizer response -> after 2047 WAIT cycles result_char = 8'h3F, result_valid = 1, busy = 0.
- clear_req and submit_req together in DRAW -> CLEAR entered, end_write never pulses, result_valid = 0; async reset asserted mid-WAIT -> result_char = 0 immediately and CLEAR restarts at address 0.
